// File: rtl/mem_pkt_pkg.sv
// Packet format and type encodings for the memory request ring.
// Shared by the cache-side request port and the memory controller.
package mem_pkt_pkg;

  localparam int unsigned ADDR_W  = 36;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned NUM_IDS = 16;

  localparam logic [2:0] PKT_EMPTY   = 3'b000;
  localparam logic [2:0] PKT_WR      = 3'b001;
  localparam logic [2:0] PKT_RD      = 3'b011;
  localparam logic [2:0] PKT_WR_ACK  = 3'b101;
  localparam logic [2:0] PKT_RD_DATA = 3'b110;

  // 'type' is a reserved word, so the type field is named ptype
  typedef struct packed {
    logic [2:0]        ptype;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_pkt_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } port_state_e;

  function automatic logic is_resp(input logic [2:0] t);
    return (t == PKT_WR_ACK) || (t == PKT_RD_DATA);
  endfunction

endpackage

// File: rtl/mem_req_port_id_alloc.sv
// Request-id allocator: free vector with a lowest-free-id priority encoder.
// An id freed this cycle becomes allocatable only from the next cycle.
module id_alloc
  import mem_pkt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc,
  input  logic            free_en,
  input  logic [ID_W-1:0] free_id,
  output logic            any_free,
  output logic [ID_W-1:0] alloc_id
);

  logic [NUM_IDS-1:0] free_q;
  logic [NUM_IDS-1:0] free_d;

  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_id = '0;
    for (int unsigned i = 0; i < NUM_IDS; i++) begin
      if (free_q[i] && !found) begin
        alloc_id = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign any_free = |free_q;

  always_comb begin
    free_d = free_q;
    if (alloc)   free_d[alloc_id] = 1'b0;
    if (free_en) free_d[free_id]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) free_q <= '1;
    else     free_q <= free_d;
  end

endmodule

// File: rtl/mem_req_port.sv
// Cache-side ring initiator: tags one cache request at a time with a free id,
// inserts it into the ring and consumes the matching response.
module mem_req_port #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned ADDR_W  = 36,
  parameter int unsigned NUM_IDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [3:0]        rsp_id,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [2:0]        ring_in_type,
  input  logic [3:0]        ring_in_id,
  input  logic [ADDR_W-1:0] ring_in_addr,
  input  logic [DATA_W-1:0] ring_in_data,
  output logic [2:0]        ring_out_type,
  output logic [3:0]        ring_out_id,
  output logic [ADDR_W-1:0] ring_out_addr,
  output logic [DATA_W-1:0] ring_out_data,
  output logic [4:0]        outstanding,
  output logic              err_unexpected
);

  import mem_pkt_pkg::*;

  port_state_e        state_q, state_d;
  mem_pkt_t           pend_q, pend_d;
  mem_pkt_t           ring_out_q, ring_out_d;
  mem_pkt_t           rsp_q, rsp_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_write_q, rsp_write_d;
  logic [NUM_IDS-1:0] tbl_valid_q, tbl_valid_d;
  logic [NUM_IDS-1:0] tbl_write_q, tbl_write_d;
  logic [4:0]         outstanding_q, outstanding_d;
  logic               err_q, err_d;

  logic               any_free;
  logic [ID_W-1:0]    alloc_id;
  logic               accept, consume, mismatch, insert, want_write, in_hit;

  id_alloc u_id_alloc (
    .clk      (clk),
    .rst      (rst),
    .alloc    (accept),
    .free_en  (consume),
    .free_id  (ring_in_id),
    .any_free (any_free),
    .alloc_id (alloc_id)
  );

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    tbl_valid_d   = tbl_valid_q;
    tbl_write_d   = tbl_write_q;
    ring_out_d    = {ring_in_type, ring_in_id, ring_in_addr, ring_in_data};
    rsp_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_write_d   = 1'b0;

    req_ready  = (state_q == ST_IDLE) && any_free && !rst;
    accept     = req_valid && req_ready;
    want_write = (ring_in_type == PKT_WR_ACK);
    in_hit     = is_resp(ring_in_type) && tbl_valid_q[ring_in_id];
    consume    = in_hit && (tbl_write_q[ring_in_id] == want_write);
    mismatch   = in_hit && !consume;
    // A consumed slot is free, so a pending request can take it this cycle
    insert     = (state_q == ST_SEND) && ((ring_in_type == PKT_EMPTY) || consume);

    if (consume) begin
      ring_out_d             = '0;
      tbl_valid_d[ring_in_id] = 1'b0;
      rsp_valid_d            = 1'b1;
      rsp_write_d            = want_write;
      rsp_d.id               = ring_in_id;
      rsp_d.addr             = ring_in_addr;
      rsp_d.data             = want_write ? '0 : ring_in_data;
    end

    if (insert) begin
      ring_out_d = pend_q;
      state_d    = ST_IDLE;
    end

    if (accept) begin
      pend_d.ptype          = req_write ? PKT_WR : PKT_RD;
      pend_d.id             = alloc_id;
      pend_d.addr           = req_addr;
      pend_d.data           = req_write ? req_data : '0;
      tbl_valid_d[alloc_id] = 1'b1;
      tbl_write_d[alloc_id] = req_write;
      state_d               = ST_SEND;
    end

    outstanding_d = outstanding_q + 5'(accept) - 5'(consume);
    err_d         = err_q | mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pend_q        <= '0;
      ring_out_q    <= '0;
      rsp_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      tbl_valid_q   <= '0;
      tbl_write_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      ring_out_q    <= ring_out_d;
      rsp_q         <= rsp_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      tbl_valid_q   <= tbl_valid_d;
      tbl_write_q   <= tbl_write_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign ring_out_type  = ring_out_q.ptype;
  assign ring_out_id    = ring_out_q.id;
  assign ring_out_addr  = ring_out_q.addr;
  assign ring_out_data  = ring_out_q.data;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_id         = rsp_q.id;
  assign rsp_addr       = rsp_q.addr;
  assign rsp_data       = rsp_q.data;
  assign outstanding    = outstanding_q;
  assign err_unexpected = err_q;

  logic unused_rsp_type;
  assign unused_rsp_type = ^rsp_q.ptype;

endmodule

// File: tb/tb_mem_req_port.sv
// Directed and randomized checks of mem_req_port against a transaction-level
// model of the id table, pending request and ring slot behaviour.
module tb_mem_req_port;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid, rsp_write;
  logic [3:0]    rsp_id;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic [2:0]    ring_in_type = '0;
  logic [3:0]    ring_in_id = '0;
  logic [AW-1:0] ring_in_addr = '0;
  logic [DW-1:0] ring_in_data = '0;
  logic [2:0]    ring_out_type;
  logic [3:0]    ring_out_id;
  logic [AW-1:0] ring_out_addr;
  logic [DW-1:0] ring_out_data;
  logic [4:0]    outstanding;
  logic          err_unexpected;

  always #5 clk = ~clk;

  mem_req_port #(.DATA_W(DW), .ADDR_W(AW), .NUM_IDS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_id(rsp_id),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .ring_in_type(ring_in_type), .ring_in_id(ring_in_id),
    .ring_in_addr(ring_in_addr), .ring_in_data(ring_in_data),
    .ring_out_type(ring_out_type), .ring_out_id(ring_out_id),
    .ring_out_addr(ring_out_addr), .ring_out_data(ring_out_data),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which ids are in flight and of what kind, plus the
  // single request waiting for a slot.
  bit          mv[16];
  bit          mw[16];
  bit          m_pend;
  bit [2:0]    mp_type;
  bit [3:0]    mp_id;
  bit [AW-1:0] mp_addr;
  bit [DW-1:0] mp_data;
  bit          m_err;
  int          m_out;

  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mw[i] = 1'b0; end
    m_pend = 1'b0; m_err = 1'b0; m_out = 0;
  endtask

  task automatic ring_idle();
    ring_in_type = 3'b000; ring_in_id = '0; ring_in_addr = '0; ring_in_data = '0;
  endtask

  task automatic ring_set(input logic [2:0] t, input logic [3:0] id,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    ring_in_type = t; ring_in_id = id; ring_in_addr = a; ring_in_data = d;
  endtask

  // One clock cycle with the inputs currently driven.
  task automatic step();
    bit            resp, wack, cons, mism, acc, ins, e_ready;
    int            aid;
    logic [554:0]  e_ring;
    logic [553:0]  e_rsp;
    aid = -1;
    for (int i = 15; i >= 0; i--) if (!mv[i]) aid = i;
    e_ready = !m_pend && (aid >= 0);
    resp = (ring_in_type == 3'b101) || (ring_in_type == 3'b110);
    wack = (ring_in_type == 3'b101);
    cons = resp && mv[ring_in_id] && (mw[ring_in_id] == wack);
    mism = resp && mv[ring_in_id] && !cons;
    acc  = req_valid && e_ready;
    ins  = m_pend && ((ring_in_type == 3'b000) || cons);
    if (ins)       e_ring = {mp_type, mp_id, mp_addr, mp_data};
    else if (cons) e_ring = '0;
    else           e_ring = {ring_in_type, ring_in_id, ring_in_addr, ring_in_data};
    if (cons) e_rsp = {1'b1, wack, ring_in_id, ring_in_addr, (wack ? {DW{1'b0}} : ring_in_data)};
    else      e_rsp = '0;
    #1;
    chk("req_ready", 600'(req_ready), 600'(e_ready));
    @(posedge clk);
    #1;
    if (cons) mv[ring_in_id] = 1'b0;
    if (ins)  m_pend = 1'b0;
    if (acc) begin
      mv[aid] = 1'b1;
      mw[aid] = req_write;
      m_pend  = 1'b1;
      mp_type = req_write ? 3'b001 : 3'b011;
      mp_id   = 4'(aid);
      mp_addr = req_addr;
      mp_data = req_write ? req_data : '0;
    end
    m_out = m_out + int'(acc) - int'(cons);
    m_err = m_err | mism;
    chk("ring_out", 600'({ring_out_type, ring_out_id, ring_out_addr, ring_out_data}), 600'(e_ring));
    chk("rsp", 600'({rsp_valid, rsp_write, rsp_id, rsp_addr, rsp_data}), 600'(e_rsp));
    chk("outstanding", 600'(outstanding), 600'(m_out));
    chk("err", 600'(err_unexpected), 600'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    ring_idle();
    #1;
    chk("rst_ready", 600'(req_ready), 600'(0));
    chk("rst_ring", 600'({ring_out_type, ring_out_id, ring_out_addr, ring_out_data}), 600'(0));
    chk("rst_rsp", 600'({rsp_valid, rsp_write, rsp_id, rsp_addr, rsp_data}), 600'(0));
    chk("rst_cnt", 600'({outstanding, err_unexpected}), 600'(0));
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_ready_hold", 600'(req_ready), 600'(0));
    rst = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] a5, dead, rd;
    int            r, id;
    a5   = {128{4'hA, 4'h5}} ;
    dead = {64{8'hDE, 8'hAD}} >> 0;
    model_clear();
    #1;
    do_reset();

    // Read miss
    ring_idle();
    issue(1'b0, 36'h0_0000_1040, '0);
    step();
    chk("rd_pkt", 600'({ring_out_type, ring_out_id, ring_out_addr}), 600'({3'b011, 4'd0, 36'h0_0000_1040}));
    ring_set(3'b110, 4'd0, 36'h0_0000_1040, a5);
    step();
    ring_idle();
    chk("rd_rsp", 600'({rsp_valid, rsp_write, rsp_data}), 600'({1'b1, 1'b0, a5}));
    chk("rd_drain", 600'(outstanding), 600'(0));

    // Writeback
    issue(1'b1, 36'h0_0000_2080, dead);
    step();
    chk("wr_pkt", 600'({ring_out_type, ring_out_id, ring_out_data}), 600'({3'b001, 4'd0, dead}));
    ring_set(3'b101, 4'd0, 36'h0_0000_2080, dead);
    step();
    ring_idle();
    chk("wr_rsp", 600'({rsp_valid, rsp_write, rsp_data}), 600'({1'b1, 1'b1, {DW{1'b0}}}));

    // Saturation
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, AW'(36'h100 + i * 64), '0);
      step();
      chk("sat_id", 600'({ring_out_type, ring_out_id}), 600'({3'b011, 4'(i)}));
    end
    req_valid = 1'b1;
    #1;
    chk("sat_full", 600'(req_ready), 600'(0));
    step();
    ring_set(3'b110, 4'd7, 36'h7, rnd_data());
    step();
    ring_idle();
    step();
    req_valid = 1'b0;
    step();
    chk("sat_reuse", 600'({ring_out_type, ring_out_id}), 600'({3'b011, 4'd7}));
    for (int i = 0; i < 16; i++) begin
      ring_set(3'b110, 4'(i), AW'(i), rnd_data());
      step();
    end
    ring_idle();
    chk("sat_drain", 600'(outstanding), 600'(0));

    // Busy ring: foreign read request holds the slot
    issue(1'b0, 36'h0_0000_3000, '0);
    ring_set(3'b011, 4'd3, 36'h777, '0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_fwd", 600'({ring_out_type, ring_out_id, ring_out_addr}), 600'({3'b011, 4'd3, 36'h777}));
    end
    ring_idle();
    step();
    chk("busy_ins", 600'({ring_out_type, ring_out_id, ring_out_addr}), 600'({3'b011, 4'd0, 36'h0_0000_3000}));

    // Same-cycle consume and insert (id 0 outstanding)
    issue(1'b0, 36'h0_0000_4000, '0);
    rd = rnd_data();
    ring_set(3'b110, 4'd0, 36'h0_0000_3000, rd);
    step();
    ring_idle();
    chk("same_ins", 600'({ring_out_type, ring_out_id, ring_out_addr}), 600'({3'b011, 4'd1, 36'h0_0000_4000}));
    chk("same_rsp", 600'({rsp_valid, rsp_id, rsp_data}), 600'({1'b1, 4'd0, rd}));
    ring_set(3'b110, 4'd1, 36'h0_0000_4000, rnd_data());
    req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h5000;
    step();
    req_valid = 1'b0;
    ring_idle();
    chk("same_cnt", 600'(outstanding), 600'(1));
    step();
    ring_set(3'b110, 4'd0, 36'h5000, rnd_data());
    step();
    ring_idle();

    // Wrong-kind response on an outstanding read
    issue(1'b0, 36'h0_0000_6000, '0);
    step();
    ring_set(3'b101, 4'd0, 36'h6000, '0);
    step();
    ring_idle();
    chk("err_set", 600'({err_unexpected, ring_out_type, ring_out_id}), 600'({1'b1, 3'b101, 4'd0}));

    // Reset while a request is waiting for a slot
    issue(1'b1, 36'h0_0000_7000, dead);
    ring_set(3'b011, 4'd9, 36'h9, '0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_noemit", 600'(ring_out_type), 600'(0));
    end
    ring_set(3'b110, 4'd0, 36'h6000, a5);
    step();
    ring_idle();
    chk("late_fwd", 600'({ring_out_type, rsp_valid}), 600'({3'b110, 1'b0}));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'({$urandom, $urandom});
      req_data  = rnd_data();
      r  = int'($urandom_range(0, 9));
      id = int'($urandom_range(0, 15));
      if (r < 4)       ring_idle();
      else if (r < 7)  ring_set(mw[id] ? 3'b101 : 3'b110, 4'(id), AW'({$urandom, $urandom}), rnd_data());
      else if (r == 7) ring_set(mw[id] ? 3'b110 : 3'b101, 4'(id), AW'({$urandom, $urandom}), rnd_data());
      else             ring_set(3'($urandom_range(0, 7)), 4'(id), AW'({$urandom, $urandom}), rnd_data());
      step();
      if (n == 200) do_reset();
    end
    req_valid = 1'b0;
    ring_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
